// File: rtl/gpio_led_pwm_ctrl.sv
// Multi-channel LED driver with per-channel off/on/PWM/blink modes and frame-synchronous
// duty updates, plus a synchronised and debounced push-button input.
module gpio_led_pwm_ctrl #(
    parameter int CH        = 8,
    parameter int PWM_W     = 8,
    parameter int PRESC     = 48,
    parameter int BLINK_DIV = 64,
    parameter int DEB_CNT   = 48000,
    parameter bit BTN_IDLE  = 1'b1
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             wr_en,
    input  logic [4:0]       wr_ch,
    input  logic [1:0]       wr_mode,
    input  logic [PWM_W-1:0] wr_duty,
    input  logic             oe_en,
    output logic [CH-1:0]    led_o,
    output logic             led_oe,
    input  logic             btn_i,
    output logic             btn_level,
    output logic             btn_rise
);

    localparam int PRE_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DEB_W = $clog2(DEB_CNT);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESC - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [PWM_W-1:0] pwm_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;
    logic             tick;
    logic             frame_end;

    function automatic logic led_next(input logic [1:0]       m,
                                      input logic [PWM_W-1:0] cnt,
                                      input logic [PWM_W-1:0] duty,
                                      input logic             phase);
        case (m)
            2'd0:    led_next = 1'b0;
            2'd1:    led_next = 1'b1;
            2'd2:    led_next = (cnt < duty);
            default: led_next = phase && (cnt < duty);
        endcase
    endfunction

    assign tick      = (pre_cnt == PRE_LAST);
    assign frame_end = tick && (pwm_cnt == '1);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (frame_end) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Per channel: mode applies at once, duty goes via shadow and lands only on frame_end.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic             hit;
        logic [1:0]       mode;
        logic [PWM_W-1:0] shadow;
        logic [PWM_W-1:0] active;
        logic             led_q;

        assign hit = wr_en && (wr_ch == 5'(i));

        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                mode   <= '0;
                shadow <= '0;
                active <= '0;
                led_q  <= 1'b0;
            end else begin
                if (hit) begin
                    mode   <= wr_mode;
                    shadow <= wr_duty;
                end
                if (frame_end) begin
                    active <= hit ? wr_duty : shadow;
                end
                led_q <= led_next(mode, pwm_cnt, active, blink_phase);
            end
        end

        assign led_o[i] = led_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            led_oe <= 1'b0;
        end else begin
            led_oe <= oe_en;
        end
    end

    logic             btn_sync_p0;
    logic             btn_sync_p1;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_done;

    // Any return of the synchronised level to btn_level restarts the stability count.
    assign deb_done = (btn_sync_p1 != btn_level) && (deb_cnt == DEB_LAST);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            btn_sync_p0 <= BTN_IDLE;
            btn_sync_p1 <= BTN_IDLE;
            deb_cnt     <= '0;
            btn_level   <= BTN_IDLE;
            btn_rise    <= 1'b0;
        end else begin
            btn_sync_p0 <= btn_i;
            btn_sync_p1 <= btn_sync_p0;
            btn_rise    <= deb_done && btn_sync_p1;
            if (btn_sync_p1 == btn_level) begin
                deb_cnt <= '0;
            end else if (deb_done) begin
                deb_cnt   <= '0;
                btn_level <= btn_sync_p1;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpio_led_pwm_ctrl.sv
// Directed bench for gpio_led_pwm_ctrl: table of timed stimulus/expected-output records
// plus hand-written sequences for asynchronous reset and first-tick timing.
module tb_gpio_led_pwm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_ch = '0;
    logic [1:0] wr_mode = '0;
    logic [3:0] wr_duty = '0;
    logic       oe_en = 1'b0;
    logic       btn_i = 1'b0;
    logic [3:0] led_o;
    logic       led_oe;
    logic       btn_level;
    logic       btn_rise;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int         at;
        bit         rst;
        bit         wr;
        logic [4:0] ch;
        logic [1:0] mode;
        logic [3:0] duty;
        bit         oe;
        bit         btn;
        logic [3:0] led;
        bit         loe;
        bit         lvl;
        bit         rise;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    gpio_led_pwm_ctrl #(
        .CH(4), .PWM_W(4), .PRESC(2), .BLINK_DIV(2), .DEB_CNT(4), .BTN_IDLE(1'b0)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .wr_en(wr_en),
        .wr_ch(wr_ch),
        .wr_mode(wr_mode),
        .wr_duty(wr_duty),
        .oe_en(oe_en),
        .led_o(led_o),
        .led_oe(led_oe),
        .btn_i(btn_i),
        .btn_level(btn_level),
        .btn_rise(btn_rise)
    );

    function automatic void add(int at, bit rst, bit wr, logic [4:0] ch, logic [1:0] mode,
                                logic [3:0] duty, bit oe, bit btn,
                                logic [3:0] led, bit loe, bit lvl, bit rise);
        vec_t v;
        v.at = at; v.rst = rst; v.wr = wr; v.ch = ch; v.mode = mode; v.duty = duty;
        v.oe = oe; v.btn = btn; v.led = led; v.loe = loe; v.lvl = lvl; v.rise = rise;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        wr_en = 1'b0;
    endtask

    task automatic check(input string name, input logic [3:0] e_led, input logic e_oe,
                         input logic e_lvl, input logic e_rise);
        tests++;
        if (led_o !== e_led || led_oe !== e_oe || btn_level !== e_lvl || btn_rise !== e_rise) begin
            fails++;
            $display("FAIL %s: got led_o=%b led_oe=%b btn_level=%b btn_rise=%b, want led_o=%b led_oe=%b btn_level=%b btn_rise=%b",
                     name, led_o, led_oe, btn_level, btn_rise, e_led, e_oe, e_lvl, e_rise);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        oe_en = 1'b0;
        btn_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("in_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        // Ch1 PWM duty 4: dark in the write frame, then 4 ticks high per 16-tick frame.
        add(4,  1, 1, 5'd1, 2'd2, 4'd4, 0, 0, 4'b0000, 0, 0, 0);
        add(20, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(32, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(33, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0010, 0, 0, 0);
        add(40, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0010, 0, 0, 0);
        add(41, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(64, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(65, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0010, 0, 0, 0);
        // Ch0 duty 8 then 2 mid-frame; ch2 written in the frame_end cycle.
        add(2,  1, 1, 5'd0, 2'd2, 4'd8, 0, 0, 4'b0000, 0, 0, 0);
        add(33, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0001, 0, 0, 0);
        add(40, 0, 1, 5'd0, 2'd2, 4'd2, 0, 0, 4'b0001, 0, 0, 0);
        add(48, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0001, 0, 0, 0);
        add(49, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(63, 0, 1, 5'd2, 2'd2, 4'd3, 0, 0, 4'b0000, 0, 0, 0);
        add(64, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(65, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0101, 0, 0, 0);
        add(67, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0101, 0, 0, 0);
        add(69, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0100, 0, 0, 0);
        add(71, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 0, 0);
        // Ch3 blink duty 15: lit in frames 2-3 and 6-7, dark on pwm_cnt 15.
        add(0,   1, 1, 5'd3, 2'd3, 4'd15, 0, 0, 4'b0000, 0, 0, 0);
        add(50,  0, 0, 5'd0, 2'd0, 4'd0,  0, 0, 4'b0000, 0, 0, 0);
        add(64,  0, 0, 5'd0, 2'd0, 4'd0,  0, 0, 4'b0000, 0, 0, 0);
        add(65,  0, 0, 5'd0, 2'd0, 4'd0,  0, 0, 4'b1000, 0, 0, 0);
        add(94,  0, 0, 5'd0, 2'd0, 4'd0,  0, 0, 4'b1000, 0, 0, 0);
        add(95,  0, 0, 5'd0, 2'd0, 4'd0,  0, 0, 4'b0000, 0, 0, 0);
        add(97,  0, 0, 5'd0, 2'd0, 4'd0,  0, 0, 4'b1000, 0, 0, 0);
        add(128, 0, 0, 5'd0, 2'd0, 4'd0,  0, 0, 4'b0000, 0, 0, 0);
        add(130, 0, 0, 5'd0, 2'd0, 4'd0,  0, 0, 4'b0000, 0, 0, 0);
        add(160, 0, 0, 5'd0, 2'd0, 4'd0,  0, 0, 4'b0000, 0, 0, 0);
        add(193, 0, 0, 5'd0, 2'd0, 4'd0,  0, 0, 4'b1000, 0, 0, 0);
        // Button: 3-cycle glitch, held press with one rise pulse, release without pulse.
        add(2,  1, 0, 5'd0, 2'd0, 4'd0, 0, 1, 4'b0000, 0, 0, 0);
        add(3,  0, 0, 5'd0, 2'd0, 4'd0, 0, 1, 4'b0000, 0, 0, 0);
        add(4,  0, 0, 5'd0, 2'd0, 4'd0, 0, 1, 4'b0000, 0, 0, 0);
        add(5,  0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(8,  0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(12, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(15, 0, 0, 5'd0, 2'd0, 4'd0, 0, 1, 4'b0000, 0, 0, 0);
        add(20, 0, 0, 5'd0, 2'd0, 4'd0, 0, 1, 4'b0000, 0, 0, 0);
        add(21, 0, 0, 5'd0, 2'd0, 4'd0, 0, 1, 4'b0000, 0, 1, 1);
        add(22, 0, 0, 5'd0, 2'd0, 4'd0, 0, 1, 4'b0000, 0, 1, 0);
        add(30, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 1, 0);
        add(35, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 1, 0);
        add(36, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 0, 0);
        add(37, 0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0000, 0, 0, 0);
        // Ch2 always on, out-of-range channel writes ignored, led_oe one cycle behind oe_en.
        add(1,  1, 1, 5'd2, 2'd1, 4'd0, 1, 0, 4'b0000, 0, 0, 0);
        add(2,  0, 1, 5'd7, 2'd1, 4'd5, 1, 0, 4'b0000, 1, 0, 0);
        add(3,  0, 0, 5'd0, 2'd0, 4'd0, 0, 0, 4'b0100, 1, 0, 0);
        add(4,  0, 0, 5'd0, 2'd0, 4'd0, 1, 0, 4'b0100, 0, 0, 0);
        add(5,  0, 1, 5'd4, 2'd1, 4'd9, 1, 0, 4'b0100, 1, 0, 0);
        add(8,  0, 0, 5'd0, 2'd0, 4'd0, 1, 0, 4'b0100, 1, 0, 0);
        add(40, 0, 0, 5'd0, 2'd0, 4'd0, 1, 0, 4'b0100, 1, 0, 0);

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            if (vecs[k].at < cyc) begin
                tests++;
                fails++;
                $display("FAIL vec[%0d] order: cycle %0d already past target %0d", k, cyc, vecs[k].at);
            end
            while (cyc < vecs[k].at) step();
            check($sformatf("vec[%0d]@%0d", k, vecs[k].at),
                  vecs[k].led, vecs[k].loe, vecs[k].lvl, vecs[k].rise);
            wr_en   = vecs[k].wr;
            wr_ch   = vecs[k].ch;
            wr_mode = vecs[k].mode;
            wr_duty = vecs[k].duty;
            oe_en   = vecs[k].oe;
            btn_i   = vecs[k].btn;
        end

        // Asynchronous reset in the middle of activity, then first-tick timing after release.
        do_reset();
        wr_en = 1'b1; wr_ch = 5'd1; wr_mode = 2'd1; wr_duty = 4'd0;
        oe_en = 1'b1; btn_i = 1'b1;
        while (cyc < 10) step();
        check("pre_reset", 4'b0010, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        oe_en = 1'b0;
        btn_i = 1'b0;
        #1;
        check("async_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        wr_en = 1'b1; wr_ch = 5'd0; wr_mode = 2'd2; wr_duty = 4'd1;
        while (cyc < 32) step();
        check("after_rel_32", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        check("after_rel_33", 4'b0001, 1'b0, 1'b0, 1'b0);
        step();
        check("after_rel_34", 4'b0001, 1'b0, 1'b0, 1'b0);
        step();
        check("after_rel_35", 4'b0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpio_led_pwm_ctrl.md
Name: gpio_led_pwm_ctrl

Overview:
- Parametrised successor to the flat GPIO-to-LED hookup of the board top.
- Drives CH LED channels, each with an independent mode: off, on, PWM dimming or blinking-PWM.
- Duty writes are glitch-free: each channel double-buffers its duty and only applies it at a PWM frame boundary.
- Also debounces one push-button input and reports its stable level and a rising-edge event.
- Sits between the SoC GPIO conduit and the board LED/button pins, in the CLK48M domain.

Parameters:
- CH, 8, number of LED channels (1..32).
- PWM_W, 8, PWM counter/duty width in bits.
- PRESC, 48, clk cycles per PWM counter tick (>=1).
- BLINK_DIV, 64, PWM frames per blink half-period (>=1).
- DEB_CNT, 48000, cycles the synchronised button must be stable before its level is accepted (>=2).
- BTN_IDLE, 1, reset value of btn_level.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  channel configuration write strobe.
- wr_ch  in  5  target channel index.
- wr_mode  in  2  mode: 0 off, 1 on, 2 pwm, 3 blink.
- wr_duty  in  PWM_W  duty value.
- oe_en  in  1  global output-enable request.
- led_o  out  CH  LED drive values.
- led_oe  out  1  registered output enable (the top tri-states LEDs when 0).
- btn_i  in  1  raw asynchronous button.
- btn_level  out  1  debounced level.
- btn_rise  out  1  one-cycle pulse on a debounced 0->1 transition.

Behaviour:
- Reset values: all outputs asynchronously cleared (led_o=0, led_oe=0, btn_rise=0), except btn_level=BTN_IDLE.
- Reset state of internals: counters 0, blink_phase=0, all modes 0, all shadow and active duties 0, sync flops=BTN_IDLE, debounce counter 0.
- Prescaler: counts 0..PRESC-1. tick=1 in the cycle the count equals PRESC-1, then it wraps to 0.
- pwm_cnt: PWM_W bits, increments on tick, wraps from 2^PWM_W-1 to 0. frame_end = tick while pwm_cnt is all-ones.
- Blink counter: counts frame_end events 0..BLINK_DIV-1. On reaching BLINK_DIV-1 with frame_end, blink_phase toggles and the counter wraps.
- Write (wr_en=1, wr_ch<CH):
  - mode[wr_ch] and shadow[wr_ch] update at the next clock edge.
  - Mode takes effect immediately; duty takes effect only at frame_end.
- Write with wr_ch>=CH: ignored, no state change.
- frame_end: active[i] <= shadow[i] for every channel. If a write to channel i occurs in the same cycle, active[i] <= wr_duty (the write wins).
- led_o[i] is registered, so there is 1 cycle latency from pwm_cnt/mode/blink_phase to the pin:
  - mode 0 -> 0.
  - mode 1 -> 1.
  - mode 2 -> (pwm_cnt < active[i]).
  - mode 3 -> blink_phase & (pwm_cnt < active[i]).
- Duty boundaries: duty 0 gives a constant 0. Duty all-ones gives high for 2^PWM_W-1 of 2^PWM_W ticks. Full-on is only via mode 1.
- led_oe <= oe_en each cycle. led_o keeps running regardless of oe.
- Debounce:
  - btn_i passes through a 2-flop synchroniser to give s.
  - If s==btn_level, the counter clears.
  - Otherwise the counter increments. When it reaches DEB_CNT-1, btn_level <= s and the counter clears.
  - btn_rise=1 for exactly the cycle after btn_level goes 0->1. A 1->0 transition gives no pulse.
- Glitch shorter than DEB_CNT cycles: no level change, because the counter restarts on any return to btn_level.
- Reset asserted mid-frame or mid-debounce: everything returns to its reset values immediately. After release, the first tick occurs PRESC cycles later.

Test Plan (bench params: CH=4, PWM_W=4, PRESC=2, BLINK_DIV=2, DEB_CNT=4, BTN_IDLE=0):
- Reset with reset_reset_n=0 mid-operation -> led_o=0, led_oe=0, btn_level=0, btn_rise=0 in the same cycle. After release, pwm_cnt advances every 2 cycles.
- Write ch1 mode 2 duty 4 -> within the current frame led_o[1] stays 0. From the next frame, led_o[1]=1 for 4 ticks (8 cycles) of every 16-tick (32-cycle) frame.
- Ch0 mode 2 duty 8, then write duty 2 mid-frame -> duty 8 is held until the frame ends, then duty 2. Also write ch2 in the frame_end cycle -> the new duty applies in the very next frame.
- Ch3 mode 3 duty 15 -> output is PWM'd during frames 2-3, off during frames 0-1, repeating every 4 frames.
- btn_i high for 3 cycles then low -> no change to btn_level. btn_i held high -> btn_level=1 after 2 sync cycles + 4 stable cycles, btn_rise high exactly 1 cycle, later release -> btn_level=0 with no pulse.
- wr_ch=7 write, and mode 1 on ch2 with oe_en toggling -> no state change from the ch7 write. led_o[2]=1 constant, led_oe follows oe_en with 1 cycle delay.
